// File: rtl/ddr_wr_data_capture_pkg.sv
// Shared types and constants for the DDR write-data capture block.
// Command bundle, capture FSM states and burst/preamble encodings.
package ddr_wr_data_capture_pkg;

    typedef struct packed {
        logic [3:0] bl;
        logic [1:0] pre;
    } wr_cap_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRE,
        CAPTURE,
        DONE
    } cap_state_e;

    localparam logic [3:0] BL4  = 4'd4;
    localparam logic [3:0] BL8  = 4'd8;
    localparam logic [1:0] PRE1 = 2'd1;
    localparam logic [1:0] PRE2 = 2'd2;

    // Anything other than the two legal encodings falls back to BL8 / 1-cycle
    function automatic wr_cap_cmd_t wr_cap_coerce(
        input logic [3:0] bl,
        input logic [1:0] pre
    );
        wr_cap_cmd_t c;
        c.bl  = (bl == BL4) ? BL4 : BL8;
        c.pre = (pre == PRE2) ? PRE2 : PRE1;
        return c;
    endfunction

endpackage

// File: rtl/ddr_wr_data_capture_cmd_fifo.sv
// Synchronous command FIFO for queued write commands.
// A push while full is taken only when a pop frees a slot in the same cycle.
module wr_cap_cmd_fifo
    import ddr_wr_data_capture_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  wr_cap_cmd_t din,
    output wr_cap_cmd_t dout,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    wr_cap_cmd_t    mem [DEPTH];
    logic [AW:0]    wr_ptr_q;
    logic [AW:0]    rd_ptr_q;
    logic           do_push;
    logic           do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ddr_wr_data_capture.sv
// DRAM-side write burst receiver: preamble detect, strobe-driven deserializer.
// Define WR_CAP_TIMEOUT_EN to bound the wait for the write preamble.
module ddr_wr_data_capture
    import ddr_wr_data_capture_pkg::*;
#(
    parameter int DQ_W        = 8,
    parameter int MAX_BL      = 8,
    parameter int CMD_DEPTH   = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                   CK_t,
    input  logic                   reset_n,
    input  logic                   wr_cmd,
    input  logic [3:0]             wr_bl,
    input  logic [1:0]             wr_pre,
    input  logic [DQ_W-1:0]        dq,
    input  logic                   dqs_t,
    input  logic                   dqs_c,
    output logic [DQ_W*MAX_BL-1:0] wr_word,
    output logic                   wr_word_valid,
    output logic [3:0]             wr_word_bl,
    output logic                   busy,
    output logic                   cmd_full,
    output logic                   cmd_overflow,
    output logic                   dqs_err,
    output logic                   timeout_err
);

    localparam int WW = DQ_W * MAX_BL;

    cap_state_e        state_q;
    cap_state_e        state_d;
    wr_cap_cmd_t       cur_q;
    wr_cap_cmd_t       fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              cmd_drop;
    logic [1:0]        pre_cnt_q;
    logic [1:0]        pre_nxt;
    logic [3:0]        beat_cnt_q;
    logic [WW-1:0]     shift_q;
    logic              dqs_t_q;
    logic              dqs_err_q;
    logic              overflow_q;
    logic              toggle;
    logic              pre_hit;
    logic              pre_done;
    logic              last_beat;
    logic              to_hit;

    wr_cap_cmd_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk   (CK_t),
        .rst_n (reset_n),
        .push  (wr_cmd),
        .pop   (fifo_pop),
        .din   (wr_cap_coerce(wr_bl, wr_pre)),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Idle bus (dqs_t=dqs_c=1) must not count as preamble
    assign pre_hit   = dqs_t && !dqs_c;
    assign pre_nxt   = pre_cnt_q + 2'd1;
    assign pre_done  = pre_hit && (pre_nxt == cur_q.pre);
    assign toggle    = dqs_t ^ dqs_t_q;
    assign last_beat = (beat_cnt_q == cur_q.bl - 4'd1);
    assign fifo_pop  = (state_q == IDLE) && !fifo_empty;
    assign cmd_drop  = wr_cmd && fifo_full && !fifo_pop;

`ifdef WR_CAP_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            timeout_q;

    assign to_hit = (state_q == WAIT_PRE) &&
                    (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (fifo_pop)
                to_cnt_q <= '0;
            else if (state_q == WAIT_PRE)
                to_cnt_q <= to_cnt_q + 1'b1;
            timeout_q <= to_hit && !pre_done;
        end
    end

    assign timeout_err = timeout_q;
`else
    assign to_hit      = (TIMEOUT_CYC < 0);
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty)
                    state_d = WAIT_PRE;
            end
            WAIT_PRE: begin
                if (pre_done)
                    state_d = CAPTURE;
                else if (to_hit)
                    state_d = IDLE;
            end
            CAPTURE: begin
                if (!toggle)
                    state_d = IDLE;
                else if (last_beat)
                    state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wr_word_valid = 1'b0;
        wr_word       = '0;
        wr_word_bl    = '0;
        if (state_q == DONE) begin
            wr_word_valid = 1'b1;
            wr_word       = shift_q;
            wr_word_bl    = cur_q.bl;
        end
    end

    assign busy         = (state_q != IDLE) || !fifo_empty;
    assign cmd_full     = fifo_full;
    assign cmd_overflow = overflow_q;
    assign dqs_err      = dqs_err_q;

    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            cur_q      <= '0;
            pre_cnt_q  <= '0;
            beat_cnt_q <= '0;
            shift_q    <= '0;
            dqs_t_q    <= 1'b0;
            dqs_err_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            dqs_t_q   <= dqs_t;
            dqs_err_q <= (state_q == CAPTURE) && !toggle;
            if (cmd_drop)
                overflow_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (fifo_pop) begin
                        cur_q     <= fifo_dout;
                        pre_cnt_q <= '0;
                        shift_q   <= '0;
                    end
                end
                WAIT_PRE: begin
                    pre_cnt_q <= pre_hit ? pre_nxt : 2'd0;
                    if (pre_done)
                        beat_cnt_q <= '0;
                end
                CAPTURE: begin
                    if (toggle) begin
                        for (int i = 0; i < MAX_BL; i++)
                            if (beat_cnt_q == 4'(i))
                                shift_q[i*DQ_W +: DQ_W] <= dq;
                        beat_cnt_q <= beat_cnt_q + 4'd1;
                    end else begin
                        shift_q <= '0;
                    end
                end
                DONE: begin
                    shift_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_wr_data_capture.sv
// Directed bench for ddr_wr_data_capture with hand-computed burst words.
// Build with WR_CAP_TIMEOUT_EN defined to also exercise the preamble timeout.
module tb_ddr_wr_data_capture;

    logic        CK_t;
    logic        reset_n;
    logic        wr_cmd;
    logic [3:0]  wr_bl;
    logic [1:0]  wr_pre;
    logic [7:0]  dq;
    logic        dqs_t;
    logic        dqs_c;
    logic [63:0] wr_word;
    logic        wr_word_valid;
    logic [3:0]  wr_word_bl;
    logic        busy;
    logic        cmd_full;
    logic        cmd_overflow;
    logic        dqs_err;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    ddr_wr_data_capture #(
        .DQ_W        (8),
        .MAX_BL      (8),
        .CMD_DEPTH   (4),
        .TIMEOUT_CYC (16)
    ) dut (
        .CK_t          (CK_t),
        .reset_n       (reset_n),
        .wr_cmd        (wr_cmd),
        .wr_bl         (wr_bl),
        .wr_pre        (wr_pre),
        .dq            (dq),
        .dqs_t         (dqs_t),
        .dqs_c         (dqs_c),
        .wr_word       (wr_word),
        .wr_word_valid (wr_word_valid),
        .wr_word_bl    (wr_word_bl),
        .busy          (busy),
        .cmd_full      (cmd_full),
        .cmd_overflow  (cmd_overflow),
        .dqs_err       (dqs_err),
        .timeout_err   (timeout_err)
    );

    initial CK_t = 1'b0;
    always #5 CK_t = ~CK_t;

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] bl, input logic [1:0] pre);
        @(negedge CK_t);
        wr_cmd = 1'b1;
        wr_bl  = bl;
        wr_pre = pre;
        @(negedge CK_t);
        wr_cmd = 1'b0;
    endtask

    // Call at the negedge before the FSM pops (or once it already waits)
    task automatic burst(input int pre, input int bl,
                         input logic [63:0] data,
                         input logic [63:0] exp_word,
                         input logic [3:0] exp_bl, input string tag);
        logic t;
        for (int i = 0; i < pre; i++) begin
            @(negedge CK_t);
            wr_cmd = 1'b0;
            dqs_t  = 1'b1;
            dqs_c  = 1'b0;
        end
        t = 1'b1;
        for (int i = 0; i < bl; i++) begin
            @(negedge CK_t);
            wr_cmd = 1'b0;
            if (i == bl - 1)
                chk({tag, ".early"}, wr_word_valid, 0);
            t     = ~t;
            dqs_t = t;
            dqs_c = ~t;
            dq    = data[i*8 +: 8];
        end
        @(negedge CK_t);
        chk({tag, ".valid"}, wr_word_valid, 1);
        chk({tag, ".word"}, wr_word, exp_word);
        chk({tag, ".bl"}, wr_word_bl, exp_bl);
        chk({tag, ".noerr"}, dqs_err, 0);
        dqs_t = 1'b1;
        dqs_c = 1'b1;
        dq    = 8'h00;
        @(negedge CK_t);
        chk({tag, ".pulse"}, wr_word_valid, 0);
    endtask

    initial begin
        logic [63:0] d;
        logic        t;
        reset_n = 1'b0;
        wr_cmd  = 1'b0;
        wr_bl   = 4'd0;
        wr_pre  = 2'd0;
        dq      = 8'h00;
        dqs_t   = 1'b1;
        dqs_c   = 1'b1;
        #12;
        chk("rst.valid", wr_word_valid, 0);
        chk("rst.word", wr_word, 0);
        chk("rst.busy", busy, 0);
        chk("rst.full", cmd_full, 0);
        chk("rst.ovf", cmd_overflow, 0);
        chk("rst.derr", dqs_err, 0);
        chk("rst.terr", timeout_err, 0);
        #1 reset_n = 1'b1;

        issue(4'd8, 2'd1);
        burst(1, 8, 64'h8877665544332211,
              64'h8877665544332211, 4'd8, "bl8");

        issue(4'd4, 2'd2);
        burst(2, 4, 64'hFFFFFFFF_A3A2A1A0,
              64'h00000000_A3A2A1A0, 4'd4, "bl4");

        // Illegal encodings, and idle bus must not start the burst
        issue(4'd5, 2'd3);
        repeat (3) @(negedge CK_t);
        chk("coerce.wait", busy, 1);
        chk("coerce.novalid", wr_word_valid, 0);
        burst(1, 8, 64'h0F1E2D3C4B5A6978,
              64'h0F1E2D3C4B5A6978, 4'd8, "coerce");

        // Strobe stalls after beat 3, then a queued BL4 burst
        issue(4'd8, 2'd1);
        issue(4'd4, 2'd2);
        @(negedge CK_t);
        dqs_t = 1'b1;
        dqs_c = 1'b0;
        t = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CK_t);
            t     = ~t;
            dqs_t = t;
            dqs_c = ~t;
            dq    = 8'hC0 + 8'(i);
        end
        @(negedge CK_t);
        dq = 8'hEE;
        @(negedge CK_t);
        chk("derr.pulse", dqs_err, 1);
        chk("derr.novalid", wr_word_valid, 0);
        chk("derr.busy", busy, 1);
        dqs_t = 1'b1;
        dqs_c = 1'b1;
        burst(2, 4, 64'h55555555_B3B2B1B0,
              64'h00000000_B3B2B1B0, 4'd4, "derr.next");

        // Fill: one command held by the FSM plus four queued
        for (int k = 0; k < 5; k++) begin
            @(negedge CK_t);
            wr_cmd = 1'b1;
            wr_bl  = 4'd8;
            wr_pre = 2'd1;
        end
        @(negedge CK_t);
        wr_cmd = 1'b0;
        chk("ovf.full", cmd_full, 1);
        chk("ovf.none", cmd_overflow, 0);
        burst(1, 8, 64'h0123456789ABCDEF,
              64'h0123456789ABCDEF, 4'd8, "ovf.b0");
        wr_cmd = 1'b1;
        burst(1, 8, 64'hFEDCBA9876543210,
              64'hFEDCBA9876543210, 4'd8, "ovf.b1");
        chk("ovf.pushpop", cmd_overflow, 0);
        chk("ovf.stillfull", cmd_full, 1);
        wr_cmd = 1'b1;
        @(negedge CK_t);
        @(negedge CK_t);
        wr_cmd = 1'b0;
        chk("ovf.drop", cmd_overflow, 1);
        chk("ovf.full2", cmd_full, 1);
        for (int k = 0; k < 5; k++) begin
            d = {8{8'(k * 17 + 3)}} ^ 64'h0011223344556677;
            burst(1, 8, d, d, 4'd8, $sformatf("ovf.d%0d", k));
        end
        chk("ovf.drained", busy, 0);
        chk("ovf.sticky", cmd_overflow, 1);

        // Reset lands while beat 5 is on the bus
        issue(4'd8, 2'd1);
        issue(4'd8, 2'd1);
        @(negedge CK_t);
        dqs_t = 1'b1;
        dqs_c = 1'b0;
        t = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CK_t);
            t     = ~t;
            dqs_t = t;
            dqs_c = ~t;
            dq    = 8'h60 + 8'(i);
        end
        #2 reset_n = 1'b0;
        dqs_t = 1'b1;
        dqs_c = 1'b1;
        #1;
        chk("arst.busy", busy, 0);
        chk("arst.ovf", cmd_overflow, 0);
        chk("arst.valid", wr_word_valid, 0);
        chk("arst.full", cmd_full, 0);
        #1 reset_n = 1'b1;
        repeat (3) @(negedge CK_t);
        chk("arst.empty", busy, 0);
        chk("arst.stale", wr_word_valid, 0);
        issue(4'd8, 2'd1);
        burst(1, 8, 64'hF0E1D2C3B4A59687,
              64'hF0E1D2C3B4A59687, 4'd8, "arst.fresh");

`ifdef WR_CAP_TIMEOUT_EN
        issue(4'd8, 2'd1);
        repeat (16) @(negedge CK_t);
        chk("tmo.before", timeout_err, 0);
        chk("tmo.waiting", busy, 1);
        @(negedge CK_t);
        chk("tmo.pulse", timeout_err, 1);
        chk("tmo.idle", busy, 0);
        @(negedge CK_t);
        chk("tmo.clear", timeout_err, 0);
`else
        chk("tmo.off", timeout_err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
